key_scan_module: RTL and testbench
==================================

Name: key_scan_module

Overview:
- Matrix-keypad input block for the traffic-light controller; it is the reader-side counterpart of the multiplexed digit display.
- Drives a 4x4 keypad row by row with active-low row strobes and samples the active-low columns.
- Debounces presses and releases, and rejects multi-key presses.
- Converts digit keystrokes into a 0..99 duration plus a direction code (N/E/S/W) for the phase-time registers.

Parameters:
- SCAN_COUNT, 25000, clocks per row slot (one frame = 4 slots).
- DEB_FRAMES, 3, consecutive identical frames required to accept a press or a release (range 1..15).

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  reset, synchronous, active-high
- row  out  4  row strobes, active-low, one row low at a time
- col  in  4  column returns, active-low (pulled up), asynchronous to sys_clk
- key_code  out  4  index of the last accepted key, row*4+col
- key_valid  out  1  one-cycle pulse when a press is accepted
- key_held  out  1  high while the accepted key remains pressed
- set_time  out  10  committed duration, 0..99
- set_dir  out  2  committed direction: 0=N, 1=E, 2=S, 3=W
- time_valid  out  1  one-cycle pulse when set_time/set_dir update

Behaviour:
- Reset and clock:
  - Single clock domain; all state resets synchronously when sys_rst=1.
  - Reset values: row=4'b1110, key_code=0, key_valid=0, key_held=0, set_time=0, set_dir=0, time_valid=0; internal entry=0, dir=0, FSM=IDLE.
- Column synchronisation:
  - col passes through a 2-flop synchronizer before any use.
- Scan:
  - A slot counter runs 0..SCAN_COUNT-1.
  - On wrap, row rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - Synchronized columns are sampled on the last cycle of each slot, before the row rotates.
  - Reset mid-scan restarts at row 0, counter 0.
- Frame result, evaluated at the end of slot 3:
  - Exactly one low column bit across all 4 rows: candidate = row*4+col, single=1.
  - Zero, or two or more, low bits: single=0. Multi-key is treated as no key (ghost reject).
- Debounce FSM, transitions only at frame end:
  - IDLE: single=1 -> PRESS, with deb_cnt=1 and cand latched.
  - PRESS:
    - Same candidate -> deb_cnt+1.
    - Different candidate -> relatch, deb_cnt=1.
    - single=0 -> IDLE.
    - When deb_cnt reaches DEB_FRAMES: go to HELD, key_code<=cand, key_valid=1 for one cycle, key_held=1.
    - With DEB_FRAMES=1, the first frame accepts immediately.
  - HELD: any frame that is not the same single key -> RELEASE with rel_cnt=1. A different key pressed while held is not accepted until full release.
  - RELEASE:
    - single=0 -> rel_cnt+1.
    - The original key reappears -> back to HELD.
    - A different single key -> rel_cnt restarts at 1.
    - When rel_cnt reaches DEB_FRAMES -> IDLE, key_held=0.
- Key map (code: key):
  - 0:1, 1:2, 2:3, 3:A
  - 4:4, 5:5, 6:6, 7:B
  - 8:7, 9:8, 10:9, 11:C
  - 12:*, 13:0, 14:#, 15:D
- Entry logic, acts on the key_valid cycle; results are visible the next cycle:
  - Digit d: entry <= (entry % 10)*10 + d. Keeps the last two digits; entry is 7 bits and never exceeds 99.
  - A/B/C/D: dir <= 0/1/2/3.
  - *: entry <= 0. dir is unchanged.
  - #: set_time <= {3'b0, entry}, set_dir <= dir, time_valid=1 on the following cycle for exactly one cycle; entry <= 0.
  - # with no digits entered commits 0.
- Latency:
  - key_valid asserts on the clock after the frame end that completes the debounce.
  - time_valid asserts 1 clock after the '#' key_valid.
- Pulse rules:
  - key_valid and time_valid never stretch beyond one cycle.
  - A held key never repeats.

Test Plan (sim: SCAN_COUNT=4, DEB_FRAMES=3, so one frame = 16 clocks):
- Reset, then no keys for 64 clocks -> row cycles 1110,1101,1011,0111 every 4 clocks; key_valid never asserts; all outputs stay at reset values.
- Hold key '5' (col1 low only while row=1101) for 5 frames -> exactly one key_valid pulse with key_code=5 after frame 3; key_held=1 until 3 clean frames after release.
- Bounce: '5' pressed 1 frame, released 1 frame, pressed 3 frames -> single key_valid, issued at the end of the 3rd consecutive frame of the last press.
- Sequence B,4,2,# -> set_time=42, set_dir=1, one time_valid pulse. Then 1,2,3,# -> set_time=23. Then *,# -> set_time=0.
- Keys '1' and '2' pressed together for 6 frames -> no key_valid. Release '2' -> key_valid with key_code=0 after 3 frames.
- Assert sys_rst mid-HELD with entry=7 -> next cycle row=1110, key_held=0, entry cleared; a following '#' commits set_time=0.

Source files
------------

// File: rtl/key_scan_module.sv
`default_nettype none
// ============================================================================
// Module      : key_scan_module
// Description : 4x4 keypad scanner with frame debounce, ghost rejection and
//               two-digit duration / direction entry.
// Revision    : 1.0
// ============================================================================
module key_scan_module #(
    parameter int SCAN_COUNT = 25000,
    parameter int DEB_FRAMES = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [9:0] set_time,
    output logic [1:0] set_dir,
    output logic       time_valid
);

    localparam int               CNT_W      = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(SCAN_COUNT - 1);
    localparam logic [3:0]       C_DEB      = 4'(DEB_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESS   = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    logic [3:0]       r_col_meta, r_col_sync;
    logic [CNT_W-1:0] r_slot_cnt;
    logic [1:0]       r_row_idx;
    logic [1:0]       r_acc_cnt;
    logic [3:0]       r_acc_cand;
    state_t           r_state;
    logic [3:0]       r_deb_cnt, r_rel_cnt, r_cand;
    logic [6:0]       r_entry;
    logic [1:0]       r_dir;

    logic       w_slot_end, w_frame_end;
    logic [3:0] w_low;
    logic [2:0] w_row_pop, w_tot;
    logic [1:0] w_row_col;
    logic [3:0] w_here_cand, w_frame_cand, w_deb_next, w_rel_next, w_digit;
    logic       w_frame_single, w_same_held, w_is_digit;
    logic [6:0] w_entry_ones, w_entry_shift;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_col_meta <= 4'hF;
            r_col_sync <= 4'hF;
        end else begin
            r_col_meta <= col;
            r_col_sync <= r_col_meta;
        end
    end

    assign w_slot_end  = (r_slot_cnt == C_CNT_LAST);
    assign w_frame_end = w_slot_end && (r_row_idx == 2'd3);
    assign w_low       = ~r_col_sync;

    always_comb begin
        w_row_pop = 3'd0;
        w_row_col = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_low[i]) begin
                w_row_pop = w_row_pop + 3'd1;
                w_row_col = 2'(i);
            end
        end
    end

    // Low-bit count over the frame so far, including the row being sampled now
    assign w_tot          = {1'b0, r_acc_cnt} + w_row_pop;
    assign w_here_cand    = {r_row_idx, w_row_col};
    assign w_frame_single = (w_tot == 3'd1);
    assign w_frame_cand   = (r_acc_cnt == 2'd0) ? w_here_cand : r_acc_cand;
    assign w_same_held    = w_frame_single && (w_frame_cand == key_code);
    assign w_deb_next     = (r_state == ST_PRESS && r_cand == w_frame_cand) ? r_deb_cnt + 4'd1 : 4'd1;
    assign w_rel_next     = (w_frame_single || r_state == ST_HELD) ? 4'd1 : r_rel_cnt + 4'd1;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_slot_cnt <= '0;
            r_row_idx  <= 2'd0;
            row        <= 4'b1110;
            r_acc_cnt  <= 2'd0;
            r_acc_cand <= 4'd0;
        end else if (w_slot_end) begin
            r_slot_cnt <= '0;
            r_row_idx  <= r_row_idx + 2'd1;
            row        <= {row[2:0], row[3]};
            if (w_frame_end) begin
                r_acc_cnt <= 2'd0;
            end else begin
                r_acc_cnt <= (w_tot >= 3'd2) ? 2'd2 : w_tot[1:0];
                if (r_acc_cnt == 2'd0 && w_row_pop == 3'd1)
                    r_acc_cand <= w_here_cand;
            end
        end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= ST_IDLE;
            r_deb_cnt <= 4'd0;
            r_rel_cnt <= 4'd0;
            r_cand    <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (w_frame_end) begin
                case (r_state)
                    ST_IDLE, ST_PRESS: begin
                        if (!w_frame_single) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_cand <= w_frame_cand;
                            if (w_deb_next >= C_DEB) begin
                                r_state   <= ST_HELD;
                                key_code  <= w_frame_cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end else begin
                                r_state   <= ST_PRESS;
                                r_deb_cnt <= w_deb_next;
                            end
                        end
                    end
                    default: begin
                        // A new key during release only restarts the release count
                        if (w_same_held) begin
                            r_state <= ST_HELD;
                        end else if (w_rel_next >= C_DEB) begin
                            r_state  <= ST_IDLE;
                            key_held <= 1'b0;
                        end else begin
                            r_state   <= ST_RELEASE;
                            r_rel_cnt <= w_rel_next;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_is_digit = 1'b1;
        w_digit    = 4'd0;
        case (key_code)
            4'd0:    w_digit = 4'd1;
            4'd1:    w_digit = 4'd2;
            4'd2:    w_digit = 4'd3;
            4'd4:    w_digit = 4'd4;
            4'd5:    w_digit = 4'd5;
            4'd6:    w_digit = 4'd6;
            4'd8:    w_digit = 4'd7;
            4'd9:    w_digit = 4'd8;
            4'd10:   w_digit = 4'd9;
            4'd13:   w_digit = 4'd0;
            default: w_is_digit = 1'b0;
        endcase
    end

    assign w_entry_ones  = r_entry % 7'd10;
    assign w_entry_shift = w_entry_ones * 7'd10 + {3'b000, w_digit};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_entry    <= 7'd0;
            r_dir      <= 2'd0;
            set_time   <= 10'd0;
            set_dir    <= 2'd0;
            time_valid <= 1'b0;
        end else begin
            time_valid <= 1'b0;
            if (key_valid) begin
                if (w_is_digit) begin
                    r_entry <= w_entry_shift;
                end else begin
                    case (key_code)
                        4'd12: r_entry <= 7'd0;
                        4'd14: begin
                            set_time   <= {3'b000, r_entry};
                            set_dir    <= r_dir;
                            time_valid <= 1'b1;
                            r_entry    <= 7'd0;
                        end
                        default: r_dir <= key_code[3:2];
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_scan_module.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_scan_module
// Description : Randomized scoreboard bench for key_scan_module with a
//               frame-level keypad reference model.
// Revision    : 1.0
// ============================================================================
module tb_key_scan_module;

    localparam int SCAN  = 4;
    localparam int DEB   = 3;
    localparam int FRAME = 4 * SCAN;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [3:0] row, col;
    logic [3:0] key_code;
    logic       key_valid, key_held, time_valid;
    logic [9:0] set_time;
    logic [1:0] set_dir;
    logic [15:0] pressed = 16'h0;

    key_scan_module #(.SCAN_COUNT(SCAN), .DEB_FRAMES(DEB)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .set_time  (set_time),
        .set_dir   (set_dir),
        .time_valid(time_valid)
    );

    always #5 sys_clk = ~sys_clk;

    // Keypad: a pressed switch pulls its column low while its row is strobed
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            if (row[r] == 1'b0)
                for (int c = 0; c < 4; c++)
                    if (pressed[r*4+c]) col[c] = 1'b0;
    end

    int n_pass   = 0;
    int n_checks = 0;
    int cyc      = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge sys_clk) begin
        if (sys_rst) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    always @(negedge sys_clk) begin
        if (!sys_rst) check("row_strobe", int'(row), 15 ^ (1 << ((cyc / SCAN) % 4)));
    end

    typedef struct {
        int kind;   // 0 = key_valid, 1 = time_valid
        int v0;
        int v1;
        int at;
    } ev_t;
    ev_t sb[$];
    ev_t mon_e;

    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (key_valid) begin
                if (sb.size() == 0) check("kv_unexpected", 1, 0);
                else begin
                    mon_e = sb.pop_front();
                    check("kv_kind", int'(key_valid), (mon_e.kind == 0) ? 1 : 0);
                    check("kv_code", int'(key_code), mon_e.v0);
                    check("kv_cycle", cyc, mon_e.at);
                end
            end
            if (time_valid) begin
                if (sb.size() == 0) check("tv_unexpected", 1, 0);
                else begin
                    mon_e = sb.pop_front();
                    check("tv_kind", int'(time_valid), (mon_e.kind == 1) ? 1 : 0);
                    check("tv_time", int'(set_time), mon_e.v0);
                    check("tv_dir", int'(set_dir), mon_e.v1);
                    check("tv_cycle", cyc, mon_e.at);
                end
            end
        end
    end

    // Reference model: decides per frame from the recent frame history
    int digit_of[16] = '{1, 2, 3, -1, 4, 5, 6, -1, 7, 8, 9, -1, -1, 0, -1, -1};
    int m_hist[$];
    bit m_held;
    int m_code, m_entry, m_dir, frame_no;

    task automatic model_reset();
        m_hist = {};
        for (int i = 0; i < DEB; i++) m_hist.push_back(-1);
        m_held = 0; m_code = 0; m_entry = 0; m_dir = 0; frame_no = 0;
    endtask

    task automatic model_frame(input logic [15:0] mask);
        int  f = -1;
        int  at = FRAME * (frame_no + 1);
        bit  ok;
        ev_t e;
        if ($countones(mask) == 1)
            for (int i = 0; i < 16; i++) if (mask[i]) f = i;
        m_hist.push_back(f);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        if (!m_held) begin
            ok = (f >= 0);
            foreach (m_hist[i]) if (m_hist[i] != f) ok = 0;
            if (ok) begin
                m_held = 1;
                m_code = f;
                e = '{0, f, 0, at};
                sb.push_back(e);
                if (digit_of[f] >= 0) m_entry = (m_entry % 10) * 10 + digit_of[f];
                else if (f == 12) m_entry = 0;
                else if (f == 14) begin
                    e = '{1, m_entry, m_dir, at + 1};
                    sb.push_back(e);
                    m_entry = 0;
                end else m_dir = f / 4;
            end
        end else begin
            ok = 1;
            foreach (m_hist[i]) begin
                if (m_hist[i] == m_code) ok = 0;
                if (i > 0 && m_hist[i] != -1) ok = 0;
            end
            if (ok) m_held = 0;
        end
        frame_no++;
    endtask

    // Called on the falling edge just after a frame starts
    task automatic run_frame(input logic [15:0] mask);
        check("key_held", int'(key_held), int'(m_held));
        check("key_code", int'(key_code), m_code);
        pressed = mask;
        model_frame(mask);
        repeat (FRAME) @(negedge sys_clk);
    endtask

    task automatic tap(input int code, input int on, input int off);
        for (int i = 0; i < on; i++)  run_frame(16'(1) << code);
        for (int i = 0; i < off; i++) run_frame(16'h0);
    endtask

    initial begin
        int k, a, b;
        model_reset();
        repeat (3) @(negedge sys_clk);
        check("rst_row", int'(row), 4'b1110);
        check("rst_key_code", int'(key_code), 0);
        check("rst_key_valid", int'(key_valid), 0);
        check("rst_key_held", int'(key_held), 0);
        check("rst_set_time", int'(set_time), 0);
        check("rst_set_dir", int'(set_dir), 0);
        check("rst_time_valid", int'(time_valid), 0);
        sys_rst = 1'b0;

        repeat (4) run_frame(16'h0);
        check("idle_set_time", int'(set_time), 0);
        check("idle_set_dir", int'(set_dir), 0);

        tap(5, 5, 4);
        run_frame(16'(1) << 5);
        run_frame(16'h0);
        tap(5, 3, 3);

        tap(7, 3, 3); tap(4, 3, 3); tap(1, 3, 3); tap(14, 3, 3);
        check("seq_time_42", int'(set_time), 42);
        check("seq_dir_e", int'(set_dir), 1);
        tap(0, 3, 3); tap(1, 3, 3); tap(2, 3, 3); tap(14, 3, 3);
        check("seq_time_23", int'(set_time), 23);
        tap(12, 3, 3); tap(14, 3, 3);
        check("seq_time_0", int'(set_time), 0);

        repeat (6) run_frame(16'b11);
        tap(0, 4, 3);

        tap(12, 3, 3);
        repeat (5) run_frame(16'(1) << 8);
        repeat (7) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("midrst_row", int'(row), 4'b1110);
        check("midrst_key_held", int'(key_held), 0);
        sys_rst = 1'b0;
        pressed = 16'h0;
        model_reset();
        tap(14, 3, 3);
        check("midrst_commit", int'(set_time), 0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom_range(0, 15);
                b = (a + 1 + $urandom_range(0, 14)) % 16;
                repeat ($urandom_range(1, 2)) run_frame((16'(1) << a) | (16'(1) << b));
            end
            k = $urandom_range(0, 15);
            tap(k, $urandom_range(1, 5), $urandom_range(0, 4));
        end
        repeat (4) run_frame(16'h0);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
